// File: rtl/sfifo_fwft_w10_d512_pkg.sv
// sfifo_fwft_w10_d512_pkg: shared sizing for the free-pointer queue
package sfifo_fwft_w10_d512_pkg;
  localparam int DW = 10;
  localparam int DEPTH = 512;
  localparam int AW = 9;
  localparam int CW = 10;
endpackage

// File: rtl/sfifo_fwft_w10_d512_sdpram.sv
// sdpram_w10_d512: simple dual-port RAM, one write and one registered read port
module sdpram_w10_d512
  import sfifo_fwft_w10_d512_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end
endmodule

// File: rtl/sfifo_fwft_w10_d512.sv
// sfifo_fwft_w10_d512: first-word-fall-through FIFO, 512x10, with occupancy count
module sfifo_fwft_w10_d512
  import sfifo_fwft_w10_d512_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] data_count
);
  logic [AW-1:0] rptr, wptr, rptr_nx, raddr;
  logic [DW-1:0] q, byp_data;
  logic [CW-1:0] count_nx;
  logic          byp, wr_ok, rd_ok;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign rptr_nx = rptr + AW'(rd_ok);
  // RAM continuously prefetches the word behind the (next) head
  assign raddr = rptr_nx + AW'(1);
  assign count_nx = data_count + CW'(wr_ok) - CW'(rd_ok);
  sdpram_w10_d512 u_ram (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wptr),
    .wdata(din),
    .raddr(raddr),
    .q    (q)
  );
  // byp marks a prefetch that raced the write of the same address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr       <= '0;
      wptr       <= '0;
      data_count <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      dout       <= '0;
      byp        <= 1'b0;
      byp_data   <= '0;
    end else begin
      wptr       <= wptr + AW'(wr_ok);
      rptr       <= rptr_nx;
      data_count <= count_nx;
      empty      <= count_nx == '0;
      full       <= count_nx == CW'(DEPTH);
      byp        <= wr_ok && (wptr == raddr);
      byp_data   <= din;
      if (wr_ok && (empty || (rd_ok && data_count == CW'(1)))) dout <= din;
      else if (rd_ok && data_count > CW'(1)) dout <= byp ? byp_data : q;
    end
  end
endmodule

// File: tb/tb_sfifo_fwft_w10_d512.sv
// tb_sfifo_fwft_w10_d512: scoreboard bench for the FWFT free-pointer FIFO
module tb_sfifo_fwft_w10_d512;
  logic       clk, rst, wr_en, rd_en;
  logic [9:0] din, dout;
  logic       empty, full;
  logic [9:0] data_count;
  int         errors = 0;
  int         checks = 0;
  int         mcount = 0;
  logic [9:0] sb[$];

  sfifo_fwft_w10_d512 dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .data_count(data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input logic w, input logic r, input logic [9:0] d);
    logic       wa, ra;
    logic [9:0] exp;
    wr_en = w; rd_en = r; din = d;
    wa = w && mcount < 512;
    ra = r && mcount > 0;
    if (ra) begin
      exp = sb.pop_front();
      checks++;
      if (dout !== exp) begin errors++; $display("FAIL pop_data dout=%h exp=%h", dout, exp); end
    end
    if (wa) sb.push_back(d);
    mcount = mcount + (wa ? 1 : 0) - (ra ? 1 : 0);
    @(posedge clk); #1;
    checks++;
    if (data_count !== 10'(mcount)) begin errors++; $display("FAIL count got=%0d exp=%0d", data_count, mcount); end
    checks++;
    if (empty !== (mcount == 0)) begin errors++; $display("FAIL empty got=%b exp=%b", empty, mcount == 0); end
    checks++;
    if (full !== (mcount == 512)) begin errors++; $display("FAIL full got=%b exp=%b", full, mcount == 512); end
    if (mcount > 0) begin
      checks++;
      if (dout !== sb[0]) begin errors++; $display("FAIL head dout=%h exp=%h", dout, sb[0]); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({empty, full, data_count, dout} !== {1'b1, 1'b0, 10'd0, 10'd0}) begin
      errors++; $display("FAIL reset e=%b f=%b c=%0d d=%h exp 1 0 0 000", empty, full, data_count, dout);
    end
    repeat (3) cycle(1'b0, 1'b1, 10'h155);
    checks++;
    if (dout !== 10'd0) begin errors++; $display("FAIL idle_dout got=%h exp=000", dout); end
  endtask

  task automatic test_single();
    cycle(1'b1, 1'b0, 10'h2A5);
    checks++;
    if (dout !== 10'h2A5) begin errors++; $display("FAIL single_dout got=%h exp=2a5", dout); end
    cycle(1'b0, 1'b1, 10'h0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 512; i++) cycle(1'b1, 1'b0, 10'(i));
    checks++;
    if ({full, data_count, dout} !== {1'b1, 10'd512, 10'd0}) begin
      errors++; $display("FAIL fill f=%b c=%0d d=%h exp 1 512 000", full, data_count, dout);
    end
    cycle(1'b1, 1'b0, 10'h3FF);
    for (int i = 0; i < 512; i++) cycle(1'b0, 1'b1, 10'h0);
  endtask

  task automatic test_stream();
    logic [9:0] v;
    v = 10'd100;
    for (int i = 0; i < 5; i++) begin cycle(1'b1, 1'b0, v); v++; end
    for (int i = 0; i < 1000; i++) begin cycle(1'b1, 1'b1, v); v++; end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 10'h0);
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < 512; i++) cycle(1'b1, 1'b0, 10'(i) ^ 10'h155);
    cycle(1'b1, 1'b1, 10'h3FF);
    checks++;
    if (data_count !== 10'd511) begin errors++; $display("FAIL rw_full_count got=%0d exp=511", data_count); end
    for (int i = 0; i < 511; i++) cycle(1'b0, 1'b1, 10'h0);
    cycle(1'b1, 1'b1, 10'h123);
    checks++;
    if ({data_count, dout} !== {10'd1, 10'h123}) begin
      errors++; $display("FAIL rw_empty c=%0d d=%h exp 1 123", data_count, dout);
    end
    cycle(1'b0, 1'b1, 10'h0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 10'(i * 3));
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({empty, full, data_count} !== {1'b1, 1'b0, 10'd0}) begin
      errors++; $display("FAIL async_reset e=%b f=%b c=%0d exp 1 0 0", empty, full, data_count);
    end
    sb.delete();
    mcount = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 10'h011);
    checks++;
    if (dout !== 10'h011) begin errors++; $display("FAIL post_reset_dout got=%h exp=011", dout); end
    cycle(1'b0, 1'b1, 10'h0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_boundaries();
    test_async_reset();
    wr_en = 1'b0; rd_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
